// File: rtl/cmos_sender.sv
// DVP-style CMOS camera sender: streams RGB565 words as vsync/href/byte timing,
// fetching one word per pixel with protocol checking on sop/eop/underrun.
module cmos_sender #(
  parameter int unsigned COL     = 640,
  parameter int unsigned ROW     = 480,
  parameter int unsigned VS_LEN  = 4,
  parameter int unsigned V_BP    = 8,
  parameter int unsigned H_BLANK = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_send,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  output logic        din_rdy,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  dout,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CW   = (COL > 1) ? $clog2(COL) : 1;
  localparam int unsigned RW   = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int unsigned TMAX = (VS_LEN > V_BP) ? ((VS_LEN > H_BLANK) ? VS_LEN : H_BLANK)
                                                 : ((V_BP > H_BLANK) ? V_BP : H_BLANK);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
  localparam logic [TW-1:0] VS_LAST  = TW'(VS_LEN - 1);
  localparam logic [TW-1:0] VBP_LAST = TW'(V_BP - 1);
  localparam logic [TW-1:0] HB_LAST  = TW'(H_BLANK - 1);
  localparam logic          ONE_COL  = (COL == 1);
  localparam logic          ONE_PIX  = (COL == 1) && (ROW == 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            phase_q, phase_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [7:0]      lo_q, lo_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      dout_q, dout_d;
  logic            err_q, err_d;
  logic            fetch, first_fetch, last_fetch;

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    phase_d     = phase_q;
    col_d       = col_q;
    row_d       = row_q;
    lo_d        = lo_q;
    fetch       = 1'b0;
    first_fetch = 1'b0;
    last_fetch  = 1'b0;
    din_rdy     = 1'b0;
    dout_d      = '0;

    case (state_q)
      S_IDLE: begin
        // Non-sop words are drained here; the sop word is held for the first fetch.
        din_rdy = !(din_vld && din_sop);
        phase_d = 1'b0;
        col_d   = '0;
        row_d   = '0;
        tcnt_d  = '0;
        if (en_send && din_vld && din_sop) state_d = S_VSYNC;
      end
      S_VSYNC: begin
        if (tcnt_q == VS_LAST) begin
          state_d = S_VBP;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_VBP: begin
        if (tcnt_q == VBP_LAST) begin
          fetch       = 1'b1;
          first_fetch = 1'b1;
          last_fetch  = ONE_PIX;
          state_d     = S_LINE;
          tcnt_d      = '0;
          phase_d     = 1'b0;
          col_d       = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_LINE: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          dout_d  = lo_q;
        end else begin
          phase_d = 1'b0;
          if (col_q == COL_LAST) begin
            col_d  = '0;
            tcnt_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_IDLE;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = S_HBLANK;
            end
          end else begin
            fetch      = 1'b1;
            col_d      = col_q + 1'b1;
            last_fetch = (col_d == COL_LAST) && (row_q == ROW_LAST);
          end
        end
      end
      S_HBLANK: begin
        if (tcnt_q == HB_LAST) begin
          fetch      = 1'b1;
          last_fetch = ONE_COL && (row_q == ROW_LAST);
          state_d    = S_LINE;
          tcnt_d     = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fetch) begin
      din_rdy = 1'b1;
      dout_d  = din_vld ? din[15:8] : '0;
      lo_d    = din_vld ? din[7:0]  : '0;
    end

    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_LINE);
    err_d   = fetch && (!din_vld || (din_sop != first_fetch) || (din_eop != last_fetch));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      phase_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      lo_q    <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      row_q   <= row_d;
      lo_q    <= lo_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign vsync = vsync_q;
  assign href  = href_q;
  assign dout  = dout_q;
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmos_sender.sv
// Directed bench for cmos_sender with a small 4x2 frame; every cycle of each
// frame is compared against a hand-laid timeline.
module tb_cmos_sender;

  localparam int unsigned COL = 4, ROW = 2, VS_LEN = 2, V_BP = 3, H_BLANK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_send = 1'b0;
  logic [15:0] din = '0;
  logic        din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic        din_rdy, vsync, href, busy, err;
  logic [7:0]  dout;

  int n_cmp = 0;
  int n_bad = 0;

  cmos_sender #(
    .COL(COL), .ROW(ROW), .VS_LEN(VS_LEN), .V_BP(V_BP), .H_BLANK(H_BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_send(en_send), .din(din), .din_vld(din_vld),
    .din_sop(din_sop), .din_eop(din_eop), .din_rdy(din_rdy), .vsync(vsync),
    .href(href), .dout(dout), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Frame timeline (cycle 0 = IDLE cycle with sop presented):
  // vsync 1..2, VBP 3..5, line0 6..13, hblank 14..15, line1 16..23.
  logic [15:0] e_data [8];
  logic        e_vld  [8];
  logic        e_sop  [8];
  logic        e_eop  [8];
  logic [7:0]  e_errmask;
  int          fc [8] = '{5, 7, 9, 11, 15, 17, 19, 21};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_clean(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      e_data[i] = base + 16'(i);
      e_vld[i]  = 1'b1;
      e_sop[i]  = (i == 0);
      e_eop[i]  = (i == 7);
    end
    e_errmask = 8'h00;
  endtask

  task automatic run_frame(input string name, input int ncyc);
    int   k;
    bit   consume, ev, eh, eb, er, ee;
    int   p;
    logic [7:0] ed;
    k = 0;
    for (int c = 0; c < ncyc; c++) begin
      en_send = (c == 0);
      if (k < 8) begin
        din = e_data[k]; din_vld = e_vld[k]; din_sop = e_sop[k]; din_eop = e_eop[k];
      end else begin
        din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      end
      @(negedge clk);
      ev = (c >= 1 && c <= 2);
      eh = (c >= 6 && c <= 13) || (c >= 16 && c <= 23);
      eb = (c >= 1);
      er = 1'b0;
      ee = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (fc[i] == c) er = 1'b1;
        if (fc[i] + 1 == c && e_errmask[i]) ee = 1'b1;
      end
      ed = 8'h00;
      if (eh) begin
        p  = (c < 16) ? (c - 6) / 2 : 4 + (c - 16) / 2;
        ed = !e_vld[p] ? 8'h00 : (((c - 6) % 2) != 0) ? e_data[p][7:0] : e_data[p][15:8];
      end
      check($sformatf("%s c%0d vs/hr/busy/rdy/err", name, c),
            {11'd0, vsync, href, busy, din_rdy, err}, {11'd0, ev, eh, eb, er, ee});
      check($sformatf("%s c%0d dout", name, c), {8'd0, dout}, {8'd0, ed});
      consume = din_rdy && (k < 8) && (din_vld || busy);
      @(posedge clk);
      #1;
      if (consume) k++;
    end
  endtask

  task automatic idle_check(input string name);
    din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; en_send = 1'b0;
    @(negedge clk);
    check({name, " idle vs/hr/busy/rdy/err"},
          {11'd0, vsync, href, busy, din_rdy, err}, 16'h0002);
    check({name, " idle dout"}, {8'd0, dout}, 16'h0000);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values, and the IDLE ready rule while reset is held.
    #2;
    check("reset vs/hr/busy/err", {12'd0, vsync, href, busy, err}, 16'h0000);
    check("reset dout", {8'd0, dout}, 16'h0000);
    din_vld = 1'b1; din_sop = 1'b1;
    #1 check("reset rdy sop", {15'd0, din_rdy}, 16'h0000);
    din_sop = 1'b0;
    #1 check("reset rdy nonsop", {15'd0, din_rdy}, 16'h0001);
    din_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean frame, then an underrun frame back-to-back from the first IDLE cycle.
    set_clean(16'h1234);
    run_frame("clean", 24);
    set_clean(16'h1234);
    e_vld[2] = 1'b0; e_data[2] = 16'hDEAD; e_errmask = 8'b0000_0100;
    run_frame("underrun", 24);
    idle_check("after_underrun");

    // Three stray words are flushed in IDLE before the sop frame.
    for (int i = 0; i < 3; i++) begin
      din = 16'hAAA0 + 16'(i); din_vld = 1'b1; din_sop = 1'b0; din_eop = 1'b0; en_send = 1'b1;
      @(negedge clk);
      check($sformatf("flush%0d rdy/busy/vs", i), {13'd0, din_rdy, busy, vsync}, 16'h0004);
      @(posedge clk); #1;
    end
    set_clean(16'h5600);
    run_frame("flushed", 24);

    // Early eop on pixel 4, stray sop on pixel 6, missing eop on pixel 7.
    set_clean(16'h9A00);
    e_eop[4] = 1'b1; e_sop[6] = 1'b1; e_eop[7] = 1'b0; e_errmask = 8'b1101_0000;
    run_frame("badmarks", 24);
    idle_check("after_badmarks");

    // Reset in the middle of line 0 aborts immediately; next frame is clean.
    set_clean(16'h7700);
    run_frame("prereset", 10);
    rst_n = 1'b0; din_vld = 1'b1; din_sop = 1'b1; din_eop = 1'b0;
    #1;
    check("midreset vs/hr/busy/err", {12'd0, vsync, href, busy, err}, 16'h0000);
    check("midreset dout", {8'd0, dout}, 16'h0000);
    check("midreset rdy sop", {15'd0, din_rdy}, 16'h0000);
    din_vld = 1'b0; din_sop = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_clean(16'h4400);
    run_frame("postreset", 24);
    idle_check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
